// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, fetch entry layout and state type for the fetch stage
package inst_fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [1:0]  SIZE_WORD    = 2'b10;
    localparam int          ENTRY_W      = 65;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } fetch_entry_t;

    typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction bus, decode handshake and redirect signals of the fetch stage
interface inst_fetch_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_addr_error;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output id_valid, id_inst, id_pc, id_addr_error,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, id_ready
    );
    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  id_valid, id_inst, id_pc, id_addr_error,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; a full FIFO still accepts a push alongside a pop
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd, r_wr;
    logic [CW-1:0]    r_count;
    logic             w_pop, w_push;

    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: credit-limited instruction fetch with in-order buffering and redirect flush
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc, r_return_pc, r_addr;
    logic         r_req;
    logic [CW-1:0] r_out, r_discard;
    logic         w_accept, w_held, w_keep, w_adel, w_push, w_pop, w_can_issue, w_full, w_empty;
    logic [CW-1:0] w_count, w_out_next, w_count_next;
    fetch_entry_t w_push_entry, w_head;

    assign w_accept     = r_req & bus.inst_addr_ok;
    assign w_held       = r_req & ~bus.inst_addr_ok;
    assign w_keep       = bus.inst_data_ok & ~bus.redirect & (r_discard == '0);
    assign w_adel       = (r_state == RUN) & ~bus.redirect & (r_fetch_pc[1:0] != 2'b00) & ~w_full & ~r_req;
    assign w_push       = w_keep | w_adel;
    assign w_pop        = ~w_empty & bus.id_ready;
    assign w_out_next   = r_out + CW'(w_accept) - CW'(bus.inst_data_ok);
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    // Credit counts everything buffered or in flight after this cycle's updates
    assign w_can_issue  = (r_state == RUN) & ~bus.redirect & (r_fetch_pc[1:0] == 2'b00) & ~w_held &
                          (({1'b0, w_count_next} + {1'b0, w_out_next}) < (CW + 1)'(FIFO_DEPTH));
    assign w_push_entry = w_keep ? {bus.inst_rdata, r_return_pc, 1'b0} : {32'd0, r_fetch_pc, 1'b1};

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.inst_req      = r_req;
    assign bus.inst_wr       = 1'b0;
    assign bus.inst_size     = SIZE_WORD;
    assign bus.inst_addr     = r_addr;
    assign bus.inst_wdata    = 32'd0;
    assign bus.id_valid      = ~w_empty;
    assign bus.id_inst       = w_empty ? 32'd0 : w_head.inst;
    assign bus.id_pc         = w_empty ? 32'd0 : w_head.pc;
    assign bus.id_addr_error = ~w_empty & w_head.adel;

    // fetch_pc advances at issue so a held stale request never disturbs the redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_fetch_pc  <= RESET_PC;
            r_return_pc <= RESET_PC;
            r_addr      <= RESET_PC;
            r_req       <= 1'b0;
            r_out       <= '0;
            r_discard   <= '0;
        end else begin
            r_out <= w_out_next;
            r_req <= w_held | w_can_issue;
            if (w_can_issue) r_addr <= r_fetch_pc;
            if (bus.redirect) begin
                r_state     <= RUN;
                r_fetch_pc  <= bus.redirect_pc;
                r_return_pc <= bus.redirect_pc;
                r_discard   <= w_out_next + CW'(w_held);
            end else begin
                if (w_can_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_adel) r_state <= HALT;
                if (w_keep) r_return_pc <= r_return_pc + 32'd4;
                if (bus.inst_data_ok && r_discard != '0) r_discard <= r_discard - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized bus/decode environment checked against an in-order PC stream model
module tb_inst_fetch;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          ret;
    } rd_t;

    typedef struct {
        logic [31:0] rpc;
        int          amax;
        int          dmax;
        int          pre;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_adel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'hbfc00000), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, pops = 0;
    int a_max = 0, d_max = 0, rdy_pct = 100, a_wait = -1;
    bit a_block = 0, exp_done = 0, prev_held = 0, redir_now = 0;
    logic [31:0] exp_pc = 32'hbfc00000, prev_addr = '0, redir_pc = '0;
    rd_t bq[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at posedge+1
    task automatic cycle();
        int r;
        bus.redirect    = redir_now;
        bus.redirect_pc = redir_pc;
        if (bus.inst_req && !a_block) begin
            if (a_wait < 0) a_wait = $urandom_range(0, a_max);
            bus.inst_addr_ok = (a_wait == 0);
            if (a_wait > 0) a_wait--;
        end else begin
            bus.inst_addr_ok = 1'b0;
        end
        bus.inst_data_ok = bq.size() > 0 && bq[0].ret <= cyc;
        bus.inst_rdata   = bus.inst_data_ok ? (bq[0].addr ^ 32'h1234) : 32'hdeadbeef;
        bus.id_ready     = $urandom_range(0, 99) < rdy_pct;
        #1;
        if (prev_held) begin
            chk("req_hold", bus.inst_req, 1);
            chk("addr_hold", bus.inst_addr, prev_addr);
        end
        if (bus.id_valid && bus.id_ready && !redir_now) begin
            if (exp_done) begin
                chk("pop_after_halt", bus.id_valid, 0);
            end else begin
                chk("id_pc", bus.id_pc, exp_pc);
                chk("id_addr_error", bus.id_addr_error, exp_pc[1:0] != 2'b00);
                chk("id_inst", bus.id_inst, exp_pc[1:0] != 2'b00 ? 32'd0 : exp_pc ^ 32'h1234);
                if (exp_pc[1:0] != 2'b00) exp_done = 1;
                exp_pc += 4;
                pops++;
            end
        end
        if (bus.inst_data_ok) void'(bq.pop_front());
        if (bus.inst_req && bus.inst_addr_ok) begin
            r = cyc + 1 + $urandom_range(0, d_max);
            if (bq.size() > 0 && bq[$].ret >= r) r = bq[$].ret + 1;
            bq.push_back('{bus.inst_addr, r});
            a_wait = -1;
        end
        chk("outstanding_bound", bq.size() <= DEPTH, 1);
        prev_held = bus.inst_req && !bus.inst_addr_ok;
        prev_addr = bus.inst_addr;
        if (redir_now) begin
            exp_pc   = redir_pc;
            exp_done = 0;
        end
        redir_now = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!bus.inst_req && k < 6) begin
            cycle();
            k++;
        end
        chk("req_after_reset", bus.inst_req, 1);
        chk("first_addr", bus.inst_addr, 32'hbfc00000);
    endtask

    initial begin
        int p0, k;
        vecs[0] = '{32'h80001000, 0, 4, 4, 32'h80001000, 32'h80000234, 1'b0};
        vecs[1] = '{32'h80000002, 1, 1, 6, 32'h80000002, 32'h00000000, 1'b1};
        vecs[2] = '{32'h80000010, 0, 0, 3, 32'h80000010, 32'h80001224, 1'b0};
        vecs[3] = '{32'h9fc00100, 3, 3, 7, 32'h9fc00100, 32'h9fc01334, 1'b0};
        vecs[4] = '{32'h00000ffe, 2, 0, 5, 32'h00000ffe, 32'h00000000, 1'b1};
        vecs[5] = '{32'h00400000, 1, 2, 2, 32'h00400000, 32'h00401234, 1'b0};
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = 0;
        bus.redirect = 0; bus.redirect_pc = 0; bus.id_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_req", bus.inst_req, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_pc", bus.id_pc, 0);
        chk("rst_id_inst", bus.id_inst, 0);
        chk("rst_id_adel", bus.id_addr_error, 0);
        chk("inst_size", bus.inst_size, 2'b10);
        chk("inst_wr", bus.inst_wr, 0);
        chk("inst_wdata", bus.inst_wdata, 0);
        rst = 0;
        wait_req();

        // zero-wait bus, decode always ready
        p0 = pops;
        repeat (30) cycle();
        chk("zero_wait_rate", (pops - p0) >= 16, 1);

        // decode stalls: buffer fills, requests stop
        rdy_pct = 0;
        repeat (10) cycle();
        chk("stall_valid", bus.id_valid, 1);
        chk("stall_req", bus.inst_req, 0);
        chk("stall_outstanding", bq.size(), 0);
        a_block = 1; rdy_pct = 100; p0 = pops;
        repeat (5) cycle();
        chk("buffered_entries", pops - p0, DEPTH);
        a_block = 0;
        repeat (20) cycle();

        // redirect vectors
        for (int i = 0; i < 6; i++) begin
            a_max = vecs[i].amax; d_max = vecs[i].dmax; rdy_pct = 100;
            repeat (vecs[i].pre) cycle();
            redir_now = 1; redir_pc = vecs[i].rpc;
            rdy_pct = 0;
            cycle();
            k = 0;
            while (!bus.id_valid && k < 100) begin
                cycle();
                k++;
            end
            chk("vec_first_valid", bus.id_valid, 1);
            chk("vec_first_pc", bus.id_pc, vecs[i].e_pc);
            chk("vec_first_inst", bus.id_inst, vecs[i].e_inst);
            chk("vec_first_adel", bus.id_addr_error, vecs[i].e_adel);
            rdy_pct = 100;
            if (vecs[i].e_adel) begin
                repeat (10) cycle();
                repeat (5) begin
                    chk("halt_no_req", bus.inst_req, 0);
                    chk("halt_no_valid", bus.id_valid, 0);
                    chk("halt_idle_bus", bq.size(), 0);
                    cycle();
                end
            end else begin
                repeat (15) cycle();
            end
        end

        // random stalls, decode back-pressure and occasional redirects
        a_max = 3; d_max = 3; rdy_pct = 70; p0 = pops; k = 0;
        while (pops - p0 < 1000 && k < 20000) begin
            if ($urandom_range(0, 199) == 0) begin
                redir_now = 1;
                redir_pc = {16'h8000, 14'($urandom), 2'b00};
            end
            cycle();
            k++;
        end
        chk("random_fetch_count", (pops - p0) >= 1000, 1);

        // asynchronous reset in the middle of a burst
        a_max = 0; d_max = 6; rdy_pct = 100; k = 0;
        while (bq.size() != 2 && k < 50) begin
            cycle();
            k++;
        end
        chk("two_outstanding", bq.size(), 2);
        rst = 1;
        #1;
        chk("midrst_inst_req", bus.inst_req, 0);
        chk("midrst_id_valid", bus.id_valid, 0);
        chk("midrst_id_pc", bus.id_pc, 0);
        chk("midrst_id_inst", bus.id_inst, 0);
        bq.delete();
        prev_held = 0; a_wait = -1; exp_pc = 32'hbfc00000; exp_done = 0;
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0;
        @(posedge clk);
        #1;
        rst = 0; d_max = 0;
        wait_req();
        p0 = pops;
        repeat (20) cycle();
        chk("post_reset_stream", (pops - p0) >= 8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
